// File: rtl/clk_rst_sequencer_pkg.sv
// Shared types and defaults for the clock/reset sequencer: reset FSM encoding,
// default timing constants and the sequencer counter width helper.
package clk_rst_sequencer_pkg;

  localparam int DEFAULT_HALF_C = 1;
  localparam int RST_CYCLES_C   = 100;
  localparam int STAGE_GAP_C    = 16;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_SYS_REL = 2'd1,
    ST_STAGE   = 2'd2,
    ST_LOCKED  = 2'd3
  } seq_state_t;

  // Counter must reach the final release edge; never narrower than one bit.
  function automatic int seq_cnt_width(input int rst_cycles, input int num_ch,
                                       input int stage_gap);
    int w;
    w = $clog2(rst_cycles + num_ch * stage_gap + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/clk_rst_sequencer_if.sv
// Control/status bundle of the clock/reset sequencer: ratio programming in,
// divided clocks, enables and staged resets out.
interface clk_rst_sequencer_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8
);
  logic [NUM_CH*DIV_W-1:0] div_ratio;
  logic                    div_load;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       clk_en;
  logic                    rst_out_n;
  logic [NUM_CH-1:0]       ch_rst_n;
  logic                    locked;

  modport master (
    output div_ratio, div_load,
    input  clk_out, clk_en, rst_out_n, ch_rst_n, locked
  );

  modport slave (
    input  div_ratio, div_load,
    output clk_out, clk_en, rst_out_n, ch_rst_n, locked
  );
endinterface

// File: rtl/clk_div_ch.sv
// One divided-clock channel: half-period counter, toggle flop, rising-edge enable
// strobe, and a shadow/active ratio pair that only swaps at the end of a high phase.
module clk_div_ch #(
  parameter int DIV_W        = 8,
  parameter int DEFAULT_HALF = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             div_load,
  output logic             clk_out,
  output logic             clk_en
);

  logic [DIV_W-1:0] shadow_q;
  logic [DIV_W-1:0] active_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] half_m1;
  logic             at_tc;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    half_m1 = '0;
    if (active_q != '0) half_m1 = active_q - DIV_W'(1);
    at_tc = (cnt_q == half_m1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the ratio registers are plain flops, so they take the default on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= DIV_W'(DEFAULT_HALF);
      active_q <= DIV_W'(DEFAULT_HALF);
      cnt_q    <= '0;
      clk_out  <= 1'b0;
      clk_en   <= 1'b0;
    end else begin
      if (div_load) shadow_q <= div_ratio;

      if (!run) begin
        cnt_q   <= '0;
        clk_out <= 1'b0;
        clk_en  <= 1'b0;
      end else if (at_tc) begin
        cnt_q   <= '0;
        clk_out <= ~clk_out;
        clk_en  <= ~clk_out;
        // Swap ratio only when falling, so every new period starts with a low phase.
        if (clk_out) active_q <= div_load ? div_ratio : shadow_q;
      end else begin
        cnt_q  <= cnt_q + DIV_W'(1);
        clk_en <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_rst_sequencer.sv
// Clock/reset sequencer: stretched system reset, staged per-channel reset release,
// and NUM_CH glitch-free programmable clock dividers.
module clk_rst_sequencer
  import clk_rst_sequencer_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int DIV_W        = 8,
  parameter int DEFAULT_HALF = DEFAULT_HALF_C,
  parameter int RST_CYCLES   = RST_CYCLES_C,
  parameter int STAGE_GAP    = STAGE_GAP_C
) (
  input logic                 clk_in,
  input logic                 rst_in,
  clk_rst_sequencer_if.slave  bus
);

  localparam int CNT_W = seq_cnt_width(RST_CYCLES, NUM_CH, STAGE_GAP);

  seq_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_next;
  logic              sys_rel;
  logic              all_rel;
  logic [NUM_CH-1:0] ch_rel;
  logic              rst_out_n_q;
  logic              locked_q;
  logic [NUM_CH-1:0] ch_rst_n_q;
  logic [NUM_CH-1:0] clk_out_w;
  logic [NUM_CH-1:0] clk_en_w;

  // Release decisions look at the count this edge will reach, so each output
  // is registered exactly on its target edge.
  always_comb begin
    cnt_next = cnt_q + CNT_W'(1);
    sys_rel  = (cnt_next >= CNT_W'(RST_CYCLES));
    ch_rel   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_rel[i] = (cnt_next >= CNT_W'(RST_CYCLES + (i + 1) * STAGE_GAP));
    end
    all_rel = ch_rel[NUM_CH-1];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      rst_out_n_q <= 1'b0;
      ch_rst_n_q  <= '0;
      locked_q    <= 1'b0;
    end else if (state_q != ST_LOCKED) begin
      cnt_q       <= cnt_next;
      rst_out_n_q <= sys_rel;
      ch_rst_n_q  <= ch_rel;
      locked_q    <= all_rel;
      unique case (state_q)
        ST_HOLD:
          if (sys_rel) state_q <= all_rel ? ST_LOCKED : (ch_rel[0] ? ST_STAGE : ST_SYS_REL);
        ST_SYS_REL:
          if (ch_rel[0]) state_q <= all_rel ? ST_LOCKED : ST_STAGE;
        ST_STAGE:
          if (all_rel) state_q <= ST_LOCKED;
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(
      .DIV_W        (DIV_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk       (clk_in),
      .rst_n     (rst_in),
      .run       (ch_rst_n_q[i]),
      .div_ratio (bus.div_ratio[i*DIV_W +: DIV_W]),
      .div_load  (bus.div_load),
      .clk_out   (clk_out_w[i]),
      .clk_en    (clk_en_w[i])
    );
  end

  assign bus.clk_out   = clk_out_w;
  assign bus.clk_en    = clk_en_w;
  assign bus.rst_out_n = rst_out_n_q;
  assign bus.ch_rst_n  = ch_rst_n_q;
  assign bus.locked    = locked_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed bench for clk_rst_sequencer: reset staging, default divide-by-2,
// ratio reprogramming (mid-phase, zero, max, bypass, last-wins) and mid-run reset.
module tb_clk_rst_sequencer;

  localparam int RST  = 100;
  localparam int GAP  = 16;
  localparam int CH0  = RST + GAP;
  localparam int CH1  = RST + 2 * GAP;
  localparam int MAXR = 600;

  logic clk_in;
  logic rst_in;
  int   edge_n;
  int   n_checks;
  int   n_fail;
  logic cur;
  logic cur_en;
  int   carried;

  clk_rst_sequencer_if #(.NUM_CH(2), .DIV_W(8)) bus ();

  clk_rst_sequencer #(
    .NUM_CH       (2),
    .DIV_W        (8),
    .DEFAULT_HALF (1),
    .RST_CYCLES   (RST),
    .STAGE_GAP    (GAP)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Edges since the last reset release.
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) edge_n <= 0;
    else         edge_n <= edge_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk_in);
    cur    = bus.clk_out[0];
    cur_en = bus.clk_en[0];
  endtask

  task automatic pulse_load(input logic [15:0] ratio);
    bus.div_ratio = ratio;
    bus.div_load  = 1'b1;
    carried++;
    sample();
    bus.div_load  = 1'b0;
  endtask

  task automatic wait_rise(input string tag);
    int g;
    g = 0;
    carried = 0;
    while (cur !== 1'b0 && g < MAXR) begin sample(); g++; end
    while (cur !== 1'b1 && g < 2 * MAXR) begin sample(); g++; end
    check(tag, 32'(cur), 32'd1);
  endtask

  // Length of the clk_out[0] run at level lvl, including samples already consumed.
  task automatic run_len(input string tag, input logic lvl, input int exp_len);
    int len;
    int bad;
    len = carried;
    bad = 0;
    carried = 0;
    while (cur === lvl && len < MAXR) begin
      len++;
      if (cur_en !== ((lvl == 1'b1 && len == 1) ? 1'b1 : 1'b0)) bad++;
      sample();
    end
    check($sformatf("%s_len", tag), 32'(len), 32'(exp_len));
    check($sformatf("%s_en", tag), 32'(bad), 32'd0);
  endtask

  task automatic check_sequence(input string tag, input int last_edge);
    int e;
    int g;
    g = 0;
    while (edge_n < last_edge && g < last_edge + 10) begin
      @(negedge clk_in);
      g++;
      e = edge_n;
      check($sformatf("%s_rst_out_n@%0d", tag, e), 32'(bus.rst_out_n), 32'(e >= RST));
      check($sformatf("%s_ch_rst_n@%0d", tag, e), 32'(bus.ch_rst_n),
            32'({(e >= CH1), (e >= CH0)}));
      check($sformatf("%s_locked@%0d", tag, e), 32'(bus.locked), 32'(e >= CH1));
      check($sformatf("%s_clk0@%0d", tag, e), 32'(bus.clk_out[0]),
            (e > CH0) ? 32'((e - CH0) % 2) : 32'd0);
      check($sformatf("%s_en0@%0d", tag, e), 32'(bus.clk_en[0]),
            (e > CH0) ? 32'((e - CH0) % 2) : 32'd0);
      check($sformatf("%s_clk1@%0d", tag, e), 32'(bus.clk_out[1]),
            (e > CH1) ? 32'((e - CH1) % 2) : 32'd0);
    end
    check($sformatf("%s_reached", tag), 32'(edge_n), 32'(last_edge));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    carried       = 0;
    cur           = 1'b0;
    cur_en        = 1'b0;
    rst_in        = 1'b0;
    bus.div_load  = 1'b0;
    bus.div_ratio = {8'd1, 8'd1};

    // Reset state.
    repeat (3) @(negedge clk_in);
    check("rst_rst_out_n", 32'(bus.rst_out_n), 32'd0);
    check("rst_ch_rst_n", 32'(bus.ch_rst_n), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_clk_out", 32'(bus.clk_out), 32'd0);
    check("rst_clk_en", 32'(bus.clk_en), 32'd0);

    // Staged release and default divide-by-2.
    rst_in = 1'b1;
    check_sequence("seq1", 140);

    // Ratio 3, then 5 loaded one cycle into a 3-cycle high phase.
    pulse_load({8'd1, 8'd3});
    wait_rise("sync3");
    run_len("r3_hi", 1'b1, 3);
    run_len("r3_lo", 1'b0, 3);
    pulse_load({8'd1, 8'd5});
    run_len("r5_old_hi", 1'b1, 3);
    run_len("r5_lo", 1'b0, 5);
    run_len("r5_hi", 1'b1, 5);
    run_len("r5_lo2", 1'b0, 5);

    // Ratio 0 acts as 1.
    pulse_load({8'd1, 8'd0});
    run_len("r0_old_hi", 1'b1, 5);
    run_len("r0_lo", 1'b0, 1);
    run_len("r0_hi", 1'b1, 1);
    run_len("r0_lo2", 1'b0, 1);

    // Load lands on the falling terminal count: 255 bypasses the stale shadow.
    pulse_load({8'd1, 8'd255});
    run_len("byp_hi", 1'b1, 1);
    run_len("r255_lo", 1'b0, 255);
    run_len("r255_hi", 1'b1, 255);
    run_len("r255_lo2", 1'b0, 255);

    // Two loads before the update point: the last one wins.
    pulse_load({8'd1, 8'd7});
    pulse_load({8'd1, 8'd4});
    run_len("lw_old_hi", 1'b1, 255);
    run_len("lw_lo", 1'b0, 4);
    run_len("lw_hi", 1'b1, 4);

    // One-cycle reset pulse while locked.
    check("pre_rst_locked", 32'(bus.locked), 32'd1);
    rst_in = 1'b0;
    #1;
    check("async_rst_out_n", 32'(bus.rst_out_n), 32'd0);
    check("async_ch_rst_n", 32'(bus.ch_rst_n), 32'd0);
    check("async_locked", 32'(bus.locked), 32'd0);
    check("async_clk_out", 32'(bus.clk_out), 32'd0);
    check("async_clk_en", 32'(bus.clk_en), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    check_sequence("seq2", 140);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
